uart_rx_fifo: RTL and testbench

//  Serial receive front end: deserialises 8N1 UART frames on uart_rxd into bytes and buffers them in a small FIFO.

---
 rtl/uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Serial receive front end. Deserialises UART frames arriving on uart_rxd
//   into bytes and buffers them in a small first-word-fall-through FIFO that
//   the core drains with a valid/ready handshake.
//   Sampling uses a 2-FF synchroniser, 16x oversampling and a mid-bit decision.
//
//   Build option: define UART_RX_PARITY_EN for 8E1 frames with parity checking.
//   Without it, frames are 8N1 and parity_err is tied to 0.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   uart_rxd   in   serial line, idle high, asynchronous to clk
//   rx_data    out  byte at the FIFO head (meaningful while rx_valid=1)
//   rx_valid   out  FIFO not empty
//   rx_ready   in   consumer pops the head when rx_valid & rx_ready
//   overrun    out  1-cycle pulse: completed byte dropped because FIFO full
//   frame_err  out  1-cycle pulse: stop bit sampled low, byte dropped
//   parity_err out  1-cycle pulse: parity mismatch, byte dropped
//
// FSM states
//   state       | meaning
//   S_IDLE      | line idle, waiting for a synced 1->0 edge
//   S_START     | validating the start bit at its middle (tick 7)
//   S_DATA      | sampling 8 data bits, LSB first, every 16th tick
//   S_PARITY    | sampling the even-parity bit (parity build only)
//   S_STOP      | sampling the stop bit and deciding push / discard
//   S_WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_rx_fifo #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 115200,
  parameter int fifo_depth     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV_RAW = clk_freq / (uart_baud_rate * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(fifo_depth);
  localparam int CW      = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state, state_nx;
  logic             rxd_meta, rxd_sync, rxd_prev;
  logic             fall;
  logic [DIV_W-1:0] div_cnt;
  logic             os_tick, div_clr;
  logic [3:0]       tick_cnt, tick_nx;
  logic [2:0]       bit_idx, bit_nx;
  logic [7:0]       shift, shift_nx;
  logic             push_q, push_nx, ferr_nx;

  // Synchroniser plus one extra stage for edge detection; all idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign fall    = rxd_prev & ~rxd_sync;
  assign os_tick = (div_cnt == DIV_W'(DIV - 1));

  // Restarted on the start edge so the mid-bit samples line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (div_clr || os_tick) div_cnt <= '0;
    else div_cnt <= div_cnt + DIV_W'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_nx, perr_nx;
`endif

  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_idx;
    shift_nx = shift;
    div_clr  = 1'b0;
    push_nx  = 1'b0;
    ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx   = par_bit;
    perr_nx  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_nx = S_START;
          tick_nx  = 4'd0;
          div_clr  = 1'b1;
        end
      end
      S_START: begin
        if (os_tick) begin
          tick_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) begin
            tick_nx  = 4'd0;
            bit_nx   = 3'd0;
            state_nx = rxd_sync ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (os_tick) begin
          tick_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            shift_nx = {rxd_sync, shift[7:1]};
            bit_nx   = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (os_tick) begin
          tick_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            par_nx   = rxd_sync;
            state_nx = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (os_tick) begin
          tick_nx = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (!rxd_sync) begin
              ferr_nx  = 1'b1;
              state_nx = S_WAIT_HIGH;
            end else begin
              state_nx = S_IDLE;
`ifdef UART_RX_PARITY_EN
              // even parity: data ones plus parity bit must be even
              if (par_bit != ^shift) perr_nx = 1'b1;
              else push_nx = 1'b1;
`else
              push_nx = 1'b1;
`endif
            end
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxd_sync) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tick_cnt  <= 4'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      bit_idx   <= bit_nx;
      shift     <= shift_nx;
      push_q    <= push_nx;
      frame_err <= ferr_nx;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_nx;
      parity_err <= perr_nx;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // FIFO. shift is stable during the push cycle because the FSM is back in
  // S_IDLE and only changes shift in S_DATA.
  logic [7:0]    mem [fifo_depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, full, do_write;

  assign rx_valid = (count != '0);
  assign rx_data  = mem[rd_ptr];
  assign pop      = rx_valid & rx_ready;
  assign full     = (count == CW'(fifo_depth));
  // when full, a simultaneous pop frees the slot the write lands in
  assign do_write = push_q & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < fifo_depth; i++) mem[i] <= 8'd0;
    end else begin
      overrun <= push_q & full & ~pop;
      if (do_write) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed and randomised frames at 16 clocks per bit, checked against a
//   queue-based model of the receiver and a 4-entry FIFO.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       overrun, frame_err, parity_err;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(
    .clk_freq(16000000),
    .uart_baud_rate(1000000),
    .fifo_depth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rxd(uart_rxd),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .overrun(overrun),
    .frame_err(frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observations
  logic [7:0] got[$];
  int n_ovr = 0, n_ferr = 0, n_perr = 0, n_valid = 0, n_wide = 0, n_excl = 0;
  int first_valid = -1;
  int start_cyc = 0;
  logic prev_ovr = 0, prev_ferr = 0, prev_perr = 0;
  logic rand_ready = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) n_valid++;
      if (rx_valid && first_valid < 0) first_valid = cyc;
      if (overrun) n_ovr++;
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if ((overrun && prev_ovr) || (frame_err && prev_ferr) || (parity_err && prev_perr)) n_wide++;
      if (int'(overrun) + int'(frame_err) + int'(parity_err) > 1) n_excl++;
      prev_ovr  = overrun;
      prev_ferr = frame_err;
      prev_perr = parity_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    n_ovr = 0; n_ferr = 0; n_perr = 0; n_valid = 0;
    first_valid = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_ready) rx_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic bit_out(input logic b);
    uart_rxd = b;
    idle(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    start_cyc = cyc;
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ par_flip);
`else
    if (par_flip) bit_out(1'b1);
`endif
    bit_out(stop_bit);
    uart_rxd = 1'b1;
  endtask

  task automatic drain_and_compare(input string tag, input logic [7:0] exp_q[$]);
    rand_ready = 0;
    rx_ready = 1'b1;
    idle(12);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_errs", {overrun, frame_err, parity_err}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    // 1: single frame with rx_ready high
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(8);
    chk("t1_count", got.size(), 1);
    if (got.size() > 0) chk("t1_data", got[0], 8'hA5);
    chk("t1_valid_cycles", n_valid, 1);
    chk("t1_latency_ok", (first_valid - start_cyc >= 140) && (first_valid - start_cyc <= 170), 1'b1);
    chk("t1_errs", n_ovr + n_ferr + n_perr, 0);

    // 2: five frames into a four-entry FIFO without draining
    clear_mon();
    rx_ready = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      exp_q.push_back(8'(i));
    end
    chk("t2_no_ovr_at_4", n_ovr, 0);
    send_frame(8'h05, 1'b1, 1'b0);
    idle(4);
    chk("t2_ovr_at_5", n_ovr, 1);
    chk("t2_valid", rx_valid, 1'b1);
    chk("t2_head", rx_data, 8'h01);
    drain_and_compare("t2", exp_q);

    // 3: stop bit low
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    chk("t3_ferr", n_ferr, 1);
    chk("t3_no_byte", n_valid, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(8);
    chk("t3_next_count", got.size(), 1);
    if (got.size() > 0) chk("t3_next_data", got[0], 8'h5A);
    chk("t3_ferr_total", n_ferr, 1);

    // 4: short glitch on idle line
    clear_mon();
    uart_rxd = 1'b0;
    idle(4);
    uart_rxd = 1'b1;
    idle(40);
    chk("t4_glitch_quiet", n_valid + n_ovr + n_ferr + n_perr, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(8);
    chk("t4_count", got.size(), 1);
    if (got.size() > 0) chk("t4_data", got[0], 8'h81);

    // 5: reset during data bit 3, with one byte already buffered
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    idle(4);
    chk("t5_prefill", rx_valid, 1'b1);
    bit_out(1'b0);
    for (int i = 0; i < 3; i++) bit_out(1'b1);
    idle(8);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_outputs", {rx_data, rx_valid, overrun, frame_err, parity_err}, 12'h000);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(20);
    chk("t5_flushed", rx_valid, 1'b0);
    clear_mon();
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(8);
    chk("t5_count", got.size(), 1);
    if (got.size() > 0) chk("t5_data", got[0], 8'h55);

`ifdef UART_RX_PARITY_EN
    // 6: wrong then right parity
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    idle(8);
    chk("t6_perr", n_perr, 1);
    chk("t6_dropped", got.size(), 0);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(8);
    chk("t6_count", got.size(), 1);
    if (got.size() > 0) chk("t6_data", got[0], 8'h07);
    chk("t6_perr_total", n_perr, 1);
`endif

    // random bytes, random gaps, random consumer stalls
    clear_mon();
    exp_q.delete();
    rand_ready = 1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      exp_q.push_back(b);
      idle($urandom_range(0, 20));
    end
    drain_and_compare("rnd", exp_q);
    chk("rnd_no_ovr", n_ovr, 0);

    // random burst into a stalled consumer: first four kept, rest overrun
    clear_mon();
    exp_q.delete();
    rx_ready = 1'b0;
    n = $urandom_range(5, 7);
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, 1'b0);
      if (exp_q.size() < 4) exp_q.push_back(b);
    end
    idle(4);
    chk("burst_ovr", n_ovr, n - 4);
    drain_and_compare("burst", exp_q);

    chk("pulse_width", n_wide, 0);
    chk("pulse_exclusive", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
